pulp_cluster_launcher: RTL

PULP_CLUSTER_LAUNCHER -- requirements
Module: pulp_cluster_launcher

---
 rtl/pulp_cluster_launcher.sv | 105 ++++++++++
 1 files changed

// File: rtl/pulp_cluster_launcher.sv
// pulp_cluster_launcher: launches PULP clusters, tracks EOC, applies timeout/abort and drains busy clusters.
// Macro PULP_CLUSTER_LAUNCHER_IRQ_EN enables a sticky completion interrupt on irq_o.
module pulp_cluster_launcher #(
  parameter int N_CLUSTERS = 4,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [N_CLUSTERS-1:0] cl_mask_i,
  input  logic [TIMEOUT_W-1:0]  timeout_i,
  input  logic                  abort_i,
  output logic [N_CLUSTERS-1:0] cl_fetch_en_o,
  input  logic [N_CLUSTERS-1:0] cl_eoc_i,
  input  logic [N_CLUSTERS-1:0] cl_busy_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_CLUSTERS-1:0] eoc_mask_o,
  output logic                  timeout_o,
  output logic                  irq_o,
  input  logic                  irq_clr_i
);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE} state_e;
  state_e                state_q, state_d;
  logic [N_CLUSTERS-1:0] mask_q, mask_d, fetch_q, fetch_d, eoc_q, eoc_d, eoc_hit, eoc_all;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d, cnt_q, cnt_d;
  logic                  tflag_q, tflag_d, busy_q, done_q, irq_q, irq_d, tmo_hit, full;
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    fetch_d = fetch_q;
    eoc_d   = eoc_q;
    tflag_d = tflag_q;
    eoc_hit = cl_eoc_i & mask_q;
    eoc_all = eoc_q | eoc_hit;
    full    = eoc_all == mask_q;
    tmo_hit = tmo_q != '0 && cnt_q == tmo_q;
    case (state_q)
      IDLE: if (start_i) begin
        mask_d  = cl_mask_i;
        tmo_d   = timeout_i;
        cnt_d   = '0;
        tflag_d = 1'b0;
        eoc_d   = cl_mask_i != '0 ? '0 : eoc_q;
        fetch_d = cl_mask_i;
        state_d = cl_mask_i != '0 ? LAUNCH : DONE;
      end
      LAUNCH: begin
        cnt_d   = TIMEOUT_W'(1);
        fetch_d = abort_i ? '0 : fetch_q;
        state_d = abort_i ? DRAIN : RUN;
      end
      RUN: begin
        eoc_d   = eoc_all;
        cnt_d   = &cnt_q ? cnt_q : cnt_q + TIMEOUT_W'(1);
        // completion and abort both take precedence over a coincident timeout
        tflag_d = !abort_i && !full && tmo_hit;
        state_d = abort_i || full || tmo_hit ? DRAIN : RUN;
        fetch_d = abort_i || full || tmo_hit ? '0 : fetch_q & ~eoc_hit;
      end
      DRAIN: state_d = (cl_busy_i & mask_q) == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
`ifdef PULP_CLUSTER_LAUNCHER_IRQ_EN
  assign irq_d = state_d == DONE || (irq_q && !irq_clr_i);
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr_i;
  assign irq_d = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      fetch_q <= '0;
      eoc_q   <= '0;
      tflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      fetch_q <= fetch_d;
      eoc_q   <= eoc_d;
      tflag_q <= tflag_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      irq_q   <= irq_d;
    end
  end
  assign cl_fetch_en_o = fetch_q;
  assign eoc_mask_o    = eoc_q;
  assign timeout_o     = tflag_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign irq_o         = irq_q;
endmodule
